// File: rtl/block_field_ctrl.sv
// -----------------------------------------------------------------------------
// block_field_ctrl
//
// Game-logic producer for the VGA display controller. Owns a 4-column by
// 8-row field of 3-bit block colours, the game state and the score. New
// blocks are dropped at a fixed rate, placed by a 16-bit LFSR. A player
// hit clears the lowest block in the selected column.
//
// Optional feature macro: BLOCK_FIELD_SPEEDUP_EN
//   When defined, the drop period shrinks with the score:
//   period = TICK_DIV >> min(score[7:5], 3).
//
// Parameters:
//   TICK_DIV   CLK_50M cycles per drop step
//   LFSR_SEED  LFSR reset value (0 is replaced by 16'h0001)
//
// Ports:
//   CLK_50M     in   1   system clock
//   RST_N       in   1   asynchronous active-low reset
//   key_start   in   1   start/restart pulse (one cycle)
//   key_hit     in   4   hit pulses, bit i = column i
//   game_state  out  2   00 START, 01 PLAY, 10 OVER
//   score       out  8   blocks cleared, saturating at 255
//   column_0..3 out  24  [23:21] = row 0 (top) ... [2:0] = row 7 (bottom)
// -----------------------------------------------------------------------------
module block_field_ctrl #(
  parameter int          TICK_DIV  = 25_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic        key_start,
  input  logic [3:0]  key_hit,
  output logic [1:0]  game_state,
  output logic [7:0]  score,
  output logic [23:0] column_0,
  output logic [23:0] column_1,
  output logic [23:0] column_2,
  output logic [23:0] column_3
);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  // Wide enough to hold TICK_DIV itself, which the speed-up period needs.
  localparam int          TW   = $clog2(TICK_DIV + 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  state_t        state_reg, state_next;
  logic [7:0]    score_reg, score_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [15:0]   lfsr_reg, lfsr_next;
  logic [23:0]   col_reg  [4];
  logic [23:0]   col_next [4];
  logic [23:0]   post_hit [4];
  logic [23:0]   shifted  [4];
  logic [3:0]    miss_vec;
  logic          step;

  // ---------------------------------------------------------------------------
  // Drop-step timing
  // ---------------------------------------------------------------------------
`ifdef BLOCK_FIELD_SPEEDUP_EN
  logic [1:0]    speed_shift;
  logic [TW-1:0] period;

  // A score increase can shorten the period below the current count; the
  // >= compare makes the wrap happen immediately instead of running past it.
  always_comb begin
    speed_shift = score_reg[7] ? 2'd3 : score_reg[6:5];
    period      = TW'(TICK_DIV) >> speed_shift;
    if (period == '0) begin
      period = TW'(1);
    end
    step = (tick_reg >= (period - TW'(1)));
  end
`else
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  assign step = (tick_reg == TICK_LAST);
`endif

  // ---------------------------------------------------------------------------
  // Hit decode: only a single set bit counts as a hit
  // ---------------------------------------------------------------------------
  logic       hit_valid;
  logic [1:0] hit_idx;

  always_comb begin
    hit_valid = 1'b0;
    hit_idx   = 2'd0;
    case (key_hit)
      4'b0001: begin hit_valid = 1'b1; hit_idx = 2'd0; end
      4'b0010: begin hit_valid = 1'b1; hit_idx = 2'd1; end
      4'b0100: begin hit_valid = 1'b1; hit_idx = 2'd2; end
      4'b1000: begin hit_valid = 1'b1; hit_idx = 2'd3; end
      default: begin hit_valid = 1'b0; hit_idx = 2'd0; end
    endcase
  end

  // Search from the bottom slice [2:0] upward: the first occupied slice is
  // the lowest block in the column.
  logic [23:0] sel_col;
  logic [23:0] hit_mask;
  logic        hit_found;

  always_comb begin
    sel_col   = col_reg[hit_idx];
    hit_mask  = '0;
    hit_found = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (!hit_found && (sel_col[3*r +: 3] != 3'b000)) begin
        hit_mask  = 24'h000007 << (3 * r);
        hit_found = 1'b1;
      end
    end
  end

  logic hit_apply;
  assign hit_apply = (state_reg == ST_PLAY) && hit_valid && hit_found;

  // ---------------------------------------------------------------------------
  // LFSR and new top row
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr_adv;
  logic [2:0]  drop_colour;

  assign lfsr_adv    = {lfsr_reg[14:0],
                        lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  // Colour 000 means empty, so a zero draw is promoted to 111.
  assign drop_colour = (lfsr_reg[4:2] == 3'b000) ? 3'b111 : lfsr_reg[4:2];

  // Per-column datapath: hit applied first, then miss check and shift run on
  // the post-hit contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign post_hit[gi] = (hit_apply && (hit_idx == 2'(gi))) ?
                          (col_reg[gi] & ~hit_mask) : col_reg[gi];
    assign shifted[gi]  = {((lfsr_reg[1:0] == 2'(gi)) ? drop_colour : 3'b000),
                           post_hit[gi][23:3]};
    assign miss_vec[gi] = |post_hit[gi][2:0];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    score_next = score_reg;
    tick_next  = tick_reg;
    lfsr_next  = lfsr_reg;
    for (int c = 0; c < 4; c++) begin
      col_next[c] = col_reg[c];
    end

    case (state_reg)
      ST_START: begin
        tick_next  = '0;
        score_next = 8'd0;
        for (int c = 0; c < 4; c++) begin
          col_next[c] = '0;
        end
        if (key_start) begin
          state_next = ST_PLAY;
        end
      end

      ST_PLAY: begin
        tick_next = step ? '0 : tick_reg + 1'b1;
        if (step) begin
          lfsr_next = lfsr_adv;
        end
        for (int c = 0; c < 4; c++) begin
          col_next[c] = post_hit[c];
        end
        if (hit_apply && (score_reg != 8'hFF)) begin
          score_next = score_reg + 1'b1;
        end
        // Hitting an empty column ends the game and suppresses the shift.
        if (hit_valid && !hit_found) begin
          state_next = ST_OVER;
        end else if (step) begin
          if (|miss_vec) begin
            state_next = ST_OVER;
          end else begin
            for (int c = 0; c < 4; c++) begin
              col_next[c] = shifted[c];
            end
          end
        end
      end

      ST_OVER: begin
        tick_next = '0;
        if (key_start) begin
          state_next = ST_START;
          score_next = 8'd0;
          for (int c = 0; c < 4; c++) begin
            col_next[c] = '0;
          end
        end
      end

      default: begin
        state_next = ST_START;
        tick_next  = '0;
        score_next = 8'd0;
        for (int c = 0; c < 4; c++) begin
          col_next[c] = '0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_START;
      score_reg <= 8'd0;
      tick_reg  <= '0;
      lfsr_reg  <= SEED;
      for (int c = 0; c < 4; c++) begin
        col_reg[c] <= '0;
      end
    end else begin
      state_reg <= state_next;
      score_reg <= score_next;
      tick_reg  <= tick_next;
      lfsr_reg  <= lfsr_next;
      for (int c = 0; c < 4; c++) begin
        col_reg[c] <= col_next[c];
      end
    end
  end

  assign game_state = state_reg;
  assign score      = score_reg;
  assign column_0   = col_reg[0];
  assign column_1   = col_reg[1];
  assign column_2   = col_reg[2];
  assign column_3   = col_reg[3];

endmodule
